fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences the IF stage against an instruction memory with a req/ack handshake.
- Owns the fetch PC and the IF/ID pipeline register.
- Applies stall and flush requests from the hazard unit and branch/jump redirects from EX.
- Allows at most one memory request outstanding; a request that a redirect makes stale is drained and its response discarded.

Parameters:
RESET_PC, 32'h0000_0000, fetch address of the first instruction after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded into IF/ID on flush or bubble

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
StallD  in  1  hazard unit: hold IF/ID and PC
PCSrcE  in  1  EX redirect taken; also flushes IF/ID
PCTargetE  in  32  redirect target address
imem_req  out  1  instruction memory request
imem_addr  out  32  request address, stable while imem_req=1 and imem_ack=0
imem_ack  in  1  response valid; transfer occurs when imem_req&imem_ack
imem_rdata  in  32  instruction word, valid with imem_ack
Instr_IFID  out  32  IF/ID instruction
PC_IFID  out  32  IF/ID PC
PCPlus4_IFID  out  32  IF/ID PC+4
Valid_IFID  out  1  IF/ID holds a real instruction
fetch_stall  out  1  imem_req&!imem_ack (memory wait)

Behaviour:
Reset (rst=1 at edge):
- state=IDLE, PC_F=RESET_PC, imem_req=0.
- Instr_IFID=NOP_INSTR, PC_IFID=0, PCPlus4_IFID=0, Valid_IFID=0.
- Reset has priority over every other input. An outstanding request is abandoned; the memory must tolerate req dropping.

States:
- IDLE: imem_req=0. Goes to FETCH on the next cycle, unconditionally.
- FETCH: imem_req=1, imem_addr=PC_F.
  - ack, !PCSrcE, !StallD: IF/ID<={rdata,PC_F,PC_F+4,valid=1}; PC_F<=PC_F+4; stay in FETCH.
    - With same-cycle ack this sustains 1 instr/cycle.
  - ack, !PCSrcE, StallD: rdata and its PC go to the hold buffer; PC_F<=PC_F+4; IF/ID unchanged; go to HOLD.
  - no ack, !PCSrcE, !StallD: IF/ID<=bubble (NOP_INSTR, valid=0); stay in FETCH.
  - no ack, !PCSrcE, StallD: IF/ID held; stay in FETCH.
  - PCSrcE with ack: response discarded; PC_F<=PCTargetE; stay in FETCH.
  - PCSrcE without ack: drain_addr<=PC_F; PC_F<=PCTargetE; go to DRAIN.
- DRAIN: imem_req=1, imem_addr=drain_addr.
  - On ack: response discarded; go to FETCH.
  - PCSrcE while in DRAIN: PC_F<=PCTargetE (latest target wins).
  - IF/ID loads a bubble unless StallD.
- HOLD: imem_req=0.
  - !StallD: IF/ID<=buffer with valid=1; go to FETCH.
  - PCSrcE: buffer discarded; PC_F<=PCTargetE; go to FETCH.

Flush:
- PCSrcE=1 forces IF/ID to a bubble (NOP_INSTR, Valid=0) in every state.
- Flush overrides StallD.

Arithmetic:
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- PCTargetE[1:0] is forced to 2'b00.

Other rules:
- The handshake protocol is never violated: imem_addr does not change while req=1 and ack=0, including across a redirect.
- Outputs are registered. The exceptions are imem_req, imem_addr and fetch_stall, which are decoded from state and registers.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on every IF/ID load with valid=1.
  - perf_stall_cnt increments on every cycle where fetch_stall=1.
  - Both are 0 on reset and wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset release, memory always acks same cycle:
   - Addresses 0x0, 0x4, 0x8 are issued back-to-back.
   - PC_IFID=0x0, 0x4, 0x8 on consecutive cycles with Valid_IFID=1.
   - Instr_IFID matches rdata.
2. Ack delayed 3 cycles at PC 0x10:
   - imem_addr holds 0x10 for 3 cycles with fetch_stall=1.
   - IF/ID shows bubbles (0x00000013, Valid=0).
   - Then PC_IFID=0x10.
3. StallD=1 for 2 cycles coincident with ack at PC 0x20:
   - IF/ID held, imem_req=0 in HOLD.
   - After StallD falls, PC_IFID=0x20 on the next edge, followed by fetch of 0x24.
4. PCSrcE=1 with PCTargetE=0x100 while the request at 0x40 is unacked:
   - imem_addr stays 0x40 until ack; the response is discarded.
   - Next request is 0x100; IF/ID is flushed.
   - 0x40 never appears in PC_IFID.
5. PCSrcE=1 and StallD=1 in the same cycle:
   - Valid_IFID=0, Instr_IFID=0x00000013.
   - Next fetch address is PCTargetE; PCTargetE=0x203 yields 0x200.
6. Wrap and reset:
   - Redirect to 0xFFFFFFFC; the next address after it is 0x0.
   - Assert rst mid-DRAIN: next cycle imem_req=0, Valid_IFID=0; after release, fetch restarts at RESET_PC.
   - With FETCH_PERF_CNT_EN: both counters read 0 after reset.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and imem.
// The fetch controller owns req/addr; the memory answers with ack/rdata.
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns PC_F and IF/ID, runs a single-outstanding req/ack fetch.
// Optional macro FETCH_PERF_CNT_EN adds fetch and memory-stall performance counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               StallD,
   input  logic               PCSrcE,
   input  logic [31:0]        PCTargetE,
   fetch_ctrl_if.master       imem,
   output logic [31:0]        Instr_IFID,
   output logic [31:0]        PC_IFID,
   output logic [31:0]        PCPlus4_IFID,
   output logic               Valid_IFID,
   output logic               fetch_stall
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} fetchState_t;

   fetchState_t r_state;
   fetchState_t w_nextState;

   logic [31:0] r_pcF;
   logic [31:0] r_drainAddr;
   logic [31:0] r_holdInstr;
   logic [31:0] r_holdPc;
   logic [31:0] r_instrIfid;
   logic [31:0] r_pcIfid;
   logic [31:0] r_pcPlus4Ifid;
   logic        r_validIfid;

   logic        w_req;
   logic        w_ack;
   logic [31:0] w_target;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_holdPcPlus4;
   logic        w_loadValid;

   assign w_ack         = imem.imem_ack;
   assign w_target      = PCTargetE & 32'hFFFF_FFFC;
   assign w_pcPlus4     = r_pcF + 32'd4;
   assign w_holdPcPlus4 = r_holdPc + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:  w_nextState = FETCH;
         FETCH: begin
            if (PCSrcE)             w_nextState = w_ack ? FETCH : DRAIN;
            else if (w_ack && StallD) w_nextState = HOLD;
         end
         DRAIN: if (w_ack) w_nextState = FETCH;
         HOLD:  if (PCSrcE || !StallD) w_nextState = FETCH;
         default: w_nextState = IDLE;
      endcase
   end

   // A stale request keeps its own address in DRAIN so the handshake never sees addr move.
   always_comb begin
      w_req          = (r_state == FETCH) || (r_state == DRAIN);
      imem.imem_req  = w_req;
      imem.imem_addr = (r_state == DRAIN) ? r_drainAddr : r_pcF;
      fetch_stall    = w_req && !w_ack;
   end

   always_comb begin
      w_loadValid = 1'b0;
      if (!PCSrcE && !StallD) begin
         if (r_state == FETCH && w_ack) w_loadValid = 1'b1;
         if (r_state == HOLD)           w_loadValid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcF         <= RESET_PC;
         r_drainAddr   <= 32'd0;
         r_holdInstr   <= NOP_INSTR;
         r_holdPc      <= 32'd0;
         r_instrIfid   <= NOP_INSTR;
         r_pcIfid      <= 32'd0;
         r_pcPlus4Ifid <= 32'd0;
         r_validIfid   <= 1'b0;
      end else if (PCSrcE) begin
         r_pcF         <= w_target;
         r_instrIfid   <= NOP_INSTR;
         r_pcIfid      <= 32'd0;
         r_pcPlus4Ifid <= 32'd0;
         r_validIfid   <= 1'b0;
         if (r_state == FETCH && !w_ack) r_drainAddr <= r_pcF;
      end else begin
         case (r_state)
            FETCH: begin
               if (w_ack) begin
                  r_pcF <= w_pcPlus4;
                  if (StallD) begin
                     r_holdInstr <= imem.imem_rdata;
                     r_holdPc    <= r_pcF;
                  end else begin
                     r_instrIfid   <= imem.imem_rdata;
                     r_pcIfid      <= r_pcF;
                     r_pcPlus4Ifid <= w_pcPlus4;
                     r_validIfid   <= 1'b1;
                  end
               end else if (!StallD) begin
                  r_instrIfid   <= NOP_INSTR;
                  r_pcIfid      <= 32'd0;
                  r_pcPlus4Ifid <= 32'd0;
                  r_validIfid   <= 1'b0;
               end
            end
            HOLD: begin
               if (!StallD) begin
                  r_instrIfid   <= r_holdInstr;
                  r_pcIfid      <= r_holdPc;
                  r_pcPlus4Ifid <= w_holdPcPlus4;
                  r_validIfid   <= 1'b1;
               end
            end
            default: begin
               if (!StallD) begin
                  r_instrIfid   <= NOP_INSTR;
                  r_pcIfid      <= 32'd0;
                  r_pcPlus4Ifid <= 32'd0;
                  r_validIfid   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign Instr_IFID   = r_instrIfid;
   assign PC_IFID      = r_pcIfid;
   assign PCPlus4_IFID = r_pcPlus4Ifid;
   assign Valid_IFID   = r_validIfid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perfFetchCnt;
   logic [31:0] r_perfStallCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perfFetchCnt <= 32'd0;
         r_perfStallCnt <= 32'd0;
      end else begin
         if (w_loadValid) r_perfFetchCnt <= r_perfFetchCnt + 32'd1;
         if (fetch_stall) r_perfStallCnt <= r_perfStallCnt + 32'd1;
      end
   end

   assign perf_fetch_cnt = r_perfFetchCnt;
   assign perf_stall_cnt = r_perfStallCnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences,
// then random stall/redirect/latency traffic against an in-order instruction-stream model.
module tb_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallD;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] Instr_IFID;
   logic [31:0] PC_IFID;
   logic [31:0] PCPlus4_IFID;
   logic        Valid_IFID;
   logic        fetch_stall;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   fetch_ctrl_if bus();

   fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .imem(bus),
      .Instr_IFID(Instr_IFID), .PC_IFID(PC_IFID), .PCPlus4_IFID(PCPlus4_IFID),
      .Valid_IFID(Valid_IFID), .fetch_stall(fetch_stall)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        pcsrc;
      logic        ack;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;
   vec_t vecs[17];

   // Model state for the random phase.
   logic [31:0] expPc, modelPc, prevTarget, prevAddr;
   logic        modelValid, prevRst, prevStall, prevPcsrc, prevReq, prevAck;
   int          delivered, totalDelivered, stallCnt;
   logic        memPending;
   int          memCnt;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic [31:0] t, input logic a);
      StallD          = s;
      PCSrcE          = p;
      PCTargetE       = t;
      bus.imem_ack    = a;
      bus.imem_rdata  = memWord(bus.imem_addr);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkIfid(input string tag, input logic v, input logic [31:0] pc);
      checkOutput({tag, "_valid"}, {31'd0, Valid_IFID}, {31'd0, v});
      if (v) begin
         checkOutput({tag, "_pc"}, PC_IFID, pc);
         checkOutput({tag, "_instr"}, Instr_IFID, memWord(pc));
         checkOutput({tag, "_pc4"}, PCPlus4_IFID, pc + 32'd4);
      end else begin
         checkOutput({tag, "_nop"}, Instr_IFID, NOP);
      end
   endtask

   task automatic checkBus(input string tag, input logic req, input logic [31:0] addr);
      checkOutput({tag, "_req"}, {31'd0, bus.imem_req}, {31'd0, req});
      if (req) checkOutput({tag, "_addr"}, bus.imem_addr, addr);
   endtask

   task automatic setVec(input int i, input logic s, input logic p, input logic a,
                         input logic r, input logic [31:0] ad, input logic v, input logic [31:0] pc);
      vecs[i].stall = s; vecs[i].pcsrc = p; vecs[i].ack = a;
      vecs[i].expReq = r; vecs[i].expAddr = ad; vecs[i].expValid = v; vecs[i].expPc = pc;
   endtask

   // Checks the consequences of the previous edge against the in-order stream model.
   task automatic checkModel();
      if (prevRst) begin
         checkOutput("rnd_rst_req", {31'd0, bus.imem_req}, 32'd0);
         checkOutput("rnd_rst_valid", {31'd0, Valid_IFID}, 32'd0);
         expPc = RESET_PC; modelValid = 1'b0; delivered = 0;
      end else begin
         if (prevReq && !prevAck) begin
            checkOutput("rnd_hs_req", {31'd0, bus.imem_req}, 32'd1);
            checkOutput("rnd_hs_addr", bus.imem_addr, prevAddr);
         end
         if (prevPcsrc) begin
            checkOutput("rnd_flush_valid", {31'd0, Valid_IFID}, 32'd0);
            checkOutput("rnd_flush_nop", Instr_IFID, NOP);
            expPc = prevTarget & 32'hFFFF_FFFC; modelValid = 1'b0;
         end else if (!prevStall) begin
            if (Valid_IFID) begin
               checkOutput("rnd_pc", PC_IFID, expPc);
               checkOutput("rnd_instr", Instr_IFID, memWord(expPc));
               checkOutput("rnd_pc4", PCPlus4_IFID, expPc + 32'd4);
               modelValid = 1'b1; modelPc = expPc;
               expPc = expPc + 32'd4;
               delivered++; totalDelivered++;
            end else begin
               checkOutput("rnd_bubble_nop", Instr_IFID, NOP);
               modelValid = 1'b0;
            end
         end else begin
            checkOutput("rnd_hold_valid", {31'd0, Valid_IFID}, {31'd0, modelValid});
            if (modelValid) checkOutput("rnd_hold_pc", PC_IFID, modelPc);
         end
      end
   endtask

   initial begin
      logic r, s, p, a;
      logic [31:0] t;
      rst = 1'b1;
      applyStimulus(0, 0, 32'd0, 0);
      tick(); tick();
      checkBus("rst", 0, 32'd0);
      checkIfid("rst", 0, 32'd0);
      checkOutput("rst_pc", PC_IFID, 32'd0);
      rst = 1'b0;

      setVec(0,  0,0,0, 0,32'h00,0,32'h00);
      setVec(1,  0,0,1, 1,32'h00,0,32'h00);
      setVec(2,  0,0,1, 1,32'h04,1,32'h00);
      setVec(3,  0,0,1, 1,32'h08,1,32'h04);
      setVec(4,  0,0,1, 1,32'h0C,1,32'h08);
      setVec(5,  0,0,0, 1,32'h10,1,32'h0C);
      setVec(6,  0,0,0, 1,32'h10,0,32'h00);
      setVec(7,  0,0,0, 1,32'h10,0,32'h00);
      setVec(8,  0,0,1, 1,32'h10,0,32'h00);
      setVec(9,  0,0,1, 1,32'h14,1,32'h10);
      setVec(10, 0,0,1, 1,32'h18,1,32'h14);
      setVec(11, 0,0,1, 1,32'h1C,1,32'h18);
      setVec(12, 1,0,1, 1,32'h20,1,32'h1C);
      setVec(13, 1,0,0, 0,32'h24,1,32'h1C);
      setVec(14, 0,0,0, 0,32'h24,1,32'h1C);
      setVec(15, 0,0,1, 1,32'h24,1,32'h20);
      setVec(16, 0,0,1, 1,32'h28,1,32'h24);

      for (int i = 0; i < 17; i++) begin
         checkBus($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr);
         checkIfid($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc);
         applyStimulus(vecs[i].stall, vecs[i].pcsrc, 32'd0, vecs[i].ack);
         #1;
         checkOutput($sformatf("vec%0d_fstall", i), {31'd0, fetch_stall},
                     {31'd0, vecs[i].expReq && !vecs[i].ack});
         tick();
      end

      // Redirect while the request at 0x40 is outstanding.
      applyStimulus(0, 1, 32'h40, 1); tick();
      checkIfid("p4_flush", 0, 32'd0); checkBus("p4_a", 1, 32'h40);
      applyStimulus(0, 0, 32'd0, 0); tick();
      checkBus("p4_b", 1, 32'h40);
      applyStimulus(0, 1, 32'h100, 0); tick();
      checkIfid("p4_redir", 0, 32'd0); checkBus("p4_drain", 1, 32'h40);
      applyStimulus(0, 0, 32'd0, 0); #1;
      checkOutput("p4_fstall", {31'd0, fetch_stall}, 32'd1);
      tick();
      checkBus("p4_drain2", 1, 32'h40);
      applyStimulus(0, 0, 32'd0, 1); tick();
      checkBus("p4_new", 1, 32'h100); checkIfid("p4_discard", 0, 32'd0);
      applyStimulus(0, 0, 32'd0, 1); tick();
      checkIfid("p4_deliver", 1, 32'h100); checkBus("p4_next", 1, 32'h104);

      // Flush beats stall; target low bits are cleared.
      applyStimulus(1, 1, 32'h203, 1); tick();
      checkIfid("p5_flush", 0, 32'd0); checkBus("p5_tgt", 1, 32'h200);
      applyStimulus(0, 0, 32'd0, 1); tick();
      checkIfid("p5_deliver", 1, 32'h200);

      // PC wrap, then reset in the middle of a drain.
      applyStimulus(0, 1, 32'hFFFF_FFFC, 1); tick();
      checkBus("p6_top", 1, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 32'd0, 1); tick();
      checkIfid("p6_top", 1, 32'hFFFF_FFFC); checkBus("p6_wrap", 1, 32'h0);
      applyStimulus(0, 0, 32'd0, 1); tick();
      checkIfid("p6_zero", 1, 32'h0);
      applyStimulus(0, 1, 32'h300, 0); tick();
      checkBus("p6_drain", 1, 32'h4);
      rst = 1'b1;
      applyStimulus(0, 0, 32'd0, 0); tick();
      checkBus("p6_rst", 0, 32'd0); checkIfid("p6_rst", 0, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("p6_perf_fetch", perf_fetch_cnt, 32'd0);
      checkOutput("p6_perf_stall", perf_stall_cnt, 32'd0);
`endif
      rst = 1'b0;
      applyStimulus(0, 0, 32'd0, 0); tick();
      checkBus("p6_restart", 1, RESET_PC);

      // Random traffic from a fresh reset.
      rst = 1'b1;
      applyStimulus(0, 0, 32'd0, 0);
      prevRst = 1'b1; prevStall = 1'b0; prevPcsrc = 1'b0; prevTarget = 32'd0;
      prevReq = bus.imem_req; prevAck = 1'b0; prevAddr = bus.imem_addr;
      stallCnt = 0; totalDelivered = 0; delivered = 0;
      memPending = 1'b0; memCnt = 0;
      modelValid = 1'b0; modelPc = 32'd0; expPc = RESET_PC;
      tick();
      for (int k = 0; k < 4000; k++) begin
         checkModel();
         r = ($urandom_range(0, 99) == 0);
         s = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 11) == 0);
         t = $urandom;
         if (prevReq && prevAck) memPending = 1'b0;
         if (!bus.imem_req) begin
            memPending = 1'b0; a = 1'b0;
         end else begin
            if (!memPending) begin
               memPending = 1'b1; memCnt = $urandom_range(0, 3);
            end
            a = (memCnt == 0);
            if (memCnt != 0) memCnt--;
         end
         rst = r;
         applyStimulus(s, p, t, a);
         #1;
         checkOutput("rnd_fstall", {31'd0, fetch_stall}, {31'd0, bus.imem_req && !a});
         if (r) stallCnt = 0;
         else if (bus.imem_req && !a) stallCnt++;
         prevRst = r; prevStall = s; prevPcsrc = p; prevTarget = t;
         prevReq = bus.imem_req; prevAck = a; prevAddr = bus.imem_addr;
         tick();
      end
      checkModel();
      checks++;
      if (totalDelivered < 200) begin
         errors++;
         $display("[TB] FAIL rnd_progress actual=%0d required>=200", totalDelivered);
      end
`ifdef FETCH_PERF_CNT_EN
      checkOutput("rnd_perf_fetch", perf_fetch_cnt, delivered);
      checkOutput("rnd_perf_stall", perf_stall_cnt, stallCnt);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
